// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types, SFR decode table and helpers for banked_register_file
//
// Purpose: SFR slot numbering, address/mask table, FSM state type and a
// clog2 helper used for parameter-derived widths.
// Ports: none (package).

package rf_pkg;

  typedef enum logic [1:0] {
    SCRUB = 2'd0,
    IDLE  = 2'd1,
    DBG   = 2'd2
  } rf_state_e;

  localparam int SFR_SLOTS  = 8;
  localparam int SFR_PCL    = 0;
  localparam int SFR_STATUS = 1;
  localparam int SFR_FSR    = 2;
  localparam int SFR_PCLATH = 3;
  localparam int SFR_INTCON = 4;
  localparam int SFR_PIR1   = 5;
  localparam int SFR_PIE1   = 6;
  localparam int SFR_PCON   = 7;

  // Table entries are wider than any practical ADDR_W and are sliced down at
  // the point of use. A mask of 0x7F drops the bank bits, so the register is
  // mirrored into every bank; an all-ones mask pins it to one bank.
  localparam logic [15:0] SFR_ADDR [SFR_SLOTS] = '{
    16'h0002, 16'h0003, 16'h0004, 16'h000A,
    16'h000B, 16'h000C, 16'h008C, 16'h008E
  };
  localparam logic [15:0] SFR_MASK [SFR_SLOTS] = '{
    16'h007F, 16'h007F, 16'h007F, 16'h007F,
    16'h007F, 16'hFFFF, 16'hFFFF, 16'hFFFF
  };

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rf_addr_decode.sv
// rtl/rf_addr_decode.sv - combinational address decoder for banked_register_file
//
// Purpose: maps an effective address onto exactly one of: an SFR slot
// (first table match wins), a banked GPR word, a shared GPR word, or the
// external peripheral bus.
// Ports:
//   a          in   ADDR_W    effective address {bank, offset[6:0]}
//   sfr_hit    out  NUM_SFR   one-hot SFR slot match
//   gpr_hit    out  1         address maps into the GPR array
//   gpr_index  out  IDX_W     word index into the GPR array
//   ext_hit    out  1         address is unmapped, goes to peripherals

module rf_addr_decode
  import rf_pkg::*;
#(
  parameter int         NUM_BANKS    = 4,
  parameter logic [6:0] GPR_START    = 7'h20,
  parameter int         GPR_LEN      = 80,
  parameter logic [6:0] SHARED_START = 7'h70,
  parameter int         SHARED_LEN   = 16,
  parameter int         NUM_SFR      = 8,
  parameter int         ADDR_W       = 7 + clog2(NUM_BANKS),
  parameter int         IDX_W        = clog2(NUM_BANKS * GPR_LEN + SHARED_LEN)
) (
  input  logic [ADDR_W-1:0]  a,
  output logic [NUM_SFR-1:0] sfr_hit,
  output logic               gpr_hit,
  output logic [IDX_W-1:0]   gpr_index,
  output logic               ext_hit
);

  logic found;
  int   off;
  int   bank;

  always_comb begin
    sfr_hit   = '0;
    gpr_hit   = 1'b0;
    gpr_index = '0;
    ext_hit   = 1'b0;
    found     = 1'b0;
    off       = int'(a[6:0]);
    bank      = int'(a[ADDR_W-1:7]);

    for (int i = 0; i < NUM_SFR; i++) begin
      if (!found &&
          ((a & SFR_MASK[i][ADDR_W-1:0]) ==
           (SFR_ADDR[i][ADDR_W-1:0] & SFR_MASK[i][ADDR_W-1:0]))) begin
        sfr_hit[i] = 1'b1;
        found      = 1'b1;
      end
    end

    if (!found) begin
      if (off >= int'(GPR_START) && off < int'(GPR_START) + GPR_LEN) begin
        gpr_hit   = 1'b1;
        gpr_index = IDX_W'(bank * GPR_LEN + off - int'(GPR_START));
      end else if (off >= int'(SHARED_START) &&
                   off < int'(SHARED_START) + SHARED_LEN) begin
        // Shared words live after all banked words; bank bits are ignored.
        gpr_hit   = 1'b1;
        gpr_index = IDX_W'(NUM_BANKS * GPR_LEN + off - int'(SHARED_START));
      end else begin
        ext_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/banked_register_file.sv
// rtl/banked_register_file.sv - banked PIC16-class data memory with scrub and debug port
//
// Purpose: N-bank GPR RAM plus shared window, table-driven SFR strobes,
// post-reset RAM scrub and a req/ack debug access port.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   addr, wr_en, data_in      core access (addr registered into addr_q)
//   data_out                  read data for the effective address
//   sfr_wr_en, sfr_rd_data    SFR owner write strobes / current values
//   extern_en, extern_rd_data peripheral bus select / read data
//   core_hold                 core stalled, debug may own the file
//   dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  debug port
//   busy                      scrub in progress

module banked_register_file
  import rf_pkg::*;
#(
  parameter int         NUM_BANKS    = 4,
  parameter int         DATA_W       = 8,
  parameter logic [6:0] GPR_START    = 7'h20,
  parameter int         GPR_LEN      = 80,
  parameter logic [6:0] SHARED_START = 7'h70,
  parameter int         SHARED_LEN   = 16,
  parameter int         NUM_SFR      = 8,
  localparam int        ADDR_W       = 7 + clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic [NUM_SFR-1:0]        sfr_wr_en,
  input  logic [NUM_SFR*DATA_W-1:0] sfr_rd_data,
  output logic                      extern_en,
  input  logic [DATA_W-1:0]         extern_rd_data,
  input  logic                      core_hold,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [ADDR_W-1:0]         dbg_addr,
  input  logic [DATA_W-1:0]         dbg_wdata,
  output logic                      dbg_ack,
  output logic [DATA_W-1:0]         dbg_rdata,
  output logic                      busy
);

  localparam int DEPTH = NUM_BANKS * GPR_LEN + SHARED_LEN;
  localparam int IDX_W = clog2(DEPTH);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  scrub_cnt;

  logic [ADDR_W-1:0]  eff_addr;
  logic [NUM_SFR-1:0] dec_sfr;
  logic               dec_gpr;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_ext;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_val;
  logic              access_we;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  // The debug port takes over the decoder for its single DBG cycle.
  assign eff_addr = (state_q == DBG) ? dbg_addr : addr_q;

  rf_addr_decode #(
    .NUM_BANKS    (NUM_BANKS),
    .GPR_START    (GPR_START),
    .GPR_LEN      (GPR_LEN),
    .SHARED_START (SHARED_START),
    .SHARED_LEN   (SHARED_LEN),
    .NUM_SFR      (NUM_SFR),
    .ADDR_W       (ADDR_W),
    .IDX_W        (IDX_W)
  ) u_decode (
    .a         (eff_addr),
    .sfr_hit   (dec_sfr),
    .gpr_hit   (dec_gpr),
    .gpr_index (dec_idx),
    .ext_hit   (dec_ext)
  );

  always_comb begin
    rd_val = '0;
    if (dec_gpr) begin
      rd_val = mem[dec_idx];
    end else if (dec_ext) begin
      rd_val = extern_rd_data;
    end else begin
      for (int i = 0; i < NUM_SFR; i++) begin
        if (dec_sfr[i]) rd_val = sfr_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    access_we = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = dec_idx;
    mem_wdata = data_in;
    sfr_wr_en = '0;
    extern_en = 1'b0;
    data_out  = '0;
    busy      = 1'b0;

    case (state_q)
      SCRUB: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_idx   = scrub_cnt;
        mem_wdata = '0;
        if (scrub_cnt == IDX_W'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        access_we = wr_en;
        if (dbg_req && core_hold) state_d = DBG;
      end
      DBG: begin
        access_we = dbg_we;
        mem_wdata = dbg_wdata;
        state_d   = IDLE;
      end
      default: state_d = SCRUB;
    endcase

    if (state_q != SCRUB) begin
      mem_we    = access_we && dec_gpr;
      sfr_wr_en = access_we ? dec_sfr : '0;
      extern_en = dec_ext;
      data_out  = rd_val;
    end

    // Nothing lands in the RAM while reset is held.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCRUB;
      addr_q    <= '0;
      scrub_cnt <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr;
      dbg_ack <= (state_q == DBG);
      if (state_q == SCRUB) scrub_cnt <= scrub_cnt + IDX_W'(1);
      // Captured before the write lands, so a debug write returns old data.
      if (state_q == DBG) dbg_rdata <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_banked_register_file.sv
// tb/tb_banked_register_file.sv - self-checking bench for banked_register_file

module tb_banked_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  addr;
  logic        wr_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  sfr_wr_en;
  logic [63:0] sfr_rd_data;
  logic        extern_en;
  logic [7:0]  extern_rd_data;
  logic        core_hold;
  logic        dbg_req;
  logic        dbg_we;
  logic [8:0]  dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  banked_register_file dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .data_in(data_in),
    .data_out(data_out), .sfr_wr_en(sfr_wr_en), .sfr_rd_data(sfr_rd_data),
    .extern_en(extern_en), .extern_rd_data(extern_rd_data),
    .core_hold(core_hold), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: SFR list from the register map, GPR contents keyed by
  // a canonical location (shared words ignore the bank).
  logic [8:0] sfr_base [8] = '{9'h002, 9'h003, 9'h004, 9'h00A,
                               9'h00B, 9'h00C, 9'h08C, 9'h08E};
  bit         sfr_all  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  logic [7:0] gpr_m [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sfr_slot(input logic [8:0] a);
    for (int i = 0; i < 8; i++) begin
      if (sfr_all[i] ? (a[6:0] == sfr_base[i][6:0]) : (a == sfr_base[i])) return i;
    end
    return -1;
  endfunction

  // Returns -1 when the address is not a GPR word.
  function automatic int gpr_key(input logic [8:0] a);
    int off;
    off = int'(a[6:0]);
    if (sfr_slot(a) >= 0) return -1;
    if (off >= 'h20 && off < 'h70) return int'(a);
    if (off >= 'h70) return 'h1000 + off;
    return -1;
  endfunction

  function automatic logic [7:0] model_read(input logic [8:0] a);
    int s, k;
    s = sfr_slot(a);
    k = gpr_key(a);
    if (s >= 0) return sfr_rd_data[s*8 +: 8];
    if (k >= 0) return gpr_m.exists(k) ? gpr_m[k] : 8'h00;
    return extern_rd_data;
  endfunction

  function automatic void model_write(input logic [8:0] a, input logic [7:0] d);
    int k;
    k = gpr_key(a);
    if (k >= 0) gpr_m[k] = d;
  endfunction

  function automatic logic [7:0] exp_strobe(input logic [8:0] a, input logic w);
    int s;
    s = sfr_slot(a);
    if (!w || s < 0) return 8'h00;
    return 8'(1 << s);
  endfunction

  // Counts cycles with busy high starting from the current sample point.
  task automatic count_busy(output int n, output int acks);
    n = 0;
    acks = 0;
    while (busy && n < 2000) begin
      if (dbg_ack) acks++;
      if (n == 50) begin
        check("scrub_data_out", data_out, 8'h00);
        check("scrub_sfr_wr_en", sfr_wr_en, 8'h00);
        check("scrub_extern_en", extern_en, 1'b0);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic core_access(input logic [8:0] a, input logic w, input logic [7:0] d, input string tag);
    addr = a; wr_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_rd"}, data_out, model_read(a));
    check({tag, "_ext"}, extern_en, (sfr_slot(a) < 0 && gpr_key(a) < 0));
    wr_en = w; data_in = d;
    #1;
    check({tag, "_strobe"}, sfr_wr_en, exp_strobe(a, w));
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (w) model_write(a, d);
    check({tag, "_raw"}, data_out, model_read(a));
  endtask

  task automatic dbg_access(input logic we, input logic [8:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!dbg_ack && lat < 20);
    rd = dbg_rdata;
    dbg_req = 1'b0;
  endtask

  initial begin
    int n, acks, lat;
    logic [7:0] rd, exp;
    logic [8:0] a;
    logic we;

    rst = 1'b1; addr = '0; wr_en = 1'b0; data_in = '0;
    sfr_rd_data = {$urandom, $urandom}; extern_rd_data = 8'hC3;
    core_hold = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_dbg_ack", dbg_ack, 1'b0);
    check("rst_dbg_rdata", dbg_rdata, 8'h00);
    check("rst_sfr_wr_en", sfr_wr_en, 8'h00);
    check("rst_extern_en", extern_en, 1'b0);

    // Core strobes and write data must be ignored during the scrub.
    rst = 1'b0; addr = 9'h003; wr_en = 1'b1;
    count_busy(n, acks);
    wr_en = 1'b0;
    check("scrub_cycles", n, 336);
    check("scrub_acks", acks, 0);

    core_access(9'h020, 1'b0, 8'h00, "scrub0_020");
    core_access(9'h0A0, 1'b0, 8'h00, "scrub0_0A0");
    core_access(9'h1F0, 1'b0, 8'h00, "scrub0_1F0");

    core_access(9'h071, 1'b1, 8'h5A, "wr_071");
    check("shared_model", model_read(9'h1F1), 8'h5A);
    core_access(9'h0F1, 1'b0, 8'h00, "rd_0F1");
    core_access(9'h171, 1'b0, 8'h00, "rd_171");
    core_access(9'h1F1, 1'b0, 8'h00, "rd_1F1");
    core_access(9'h120, 1'b1, 8'h3C, "wr_120");
    core_access(9'h020, 1'b0, 8'h00, "rd_020");

    core_access(9'h003, 1'b1, 8'h77, "status_b0");
    core_access(9'h083, 1'b1, 8'h77, "status_b1");
    core_access(9'h183, 1'b1, 8'h77, "status_b3");
    core_access(9'h08E, 1'b1, 8'h01, "pcon_b1");
    core_access(9'h00E, 1'b1, 8'h01, "pcon_b0_ext");
    core_access(9'h005, 1'b0, 8'h00, "ext_005");

    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) begin
        sfr_rd_data = {$urandom, $urandom};
        extern_rd_data = 8'($urandom);
      end
      core_access(9'($urandom), 1'($urandom), 8'($urandom), "rand_core");
    end

    core_hold = 1'b1;
    dbg_access(1'b1, 9'h040, 8'h11, rd, lat);
    model_write(9'h040, 8'h11);
    check("dbg_wr_lat", lat, 2);
    dbg_access(1'b0, 9'h040, 8'h00, rd, lat);
    check("dbg_rd_lat", lat, 2);
    check("dbg_rd_040", rd, 8'h11);
    core_access(9'h040, 1'b0, 8'h00, "core_after_dbg");

    for (int i = 0; i < 30; i++) begin
      a = 9'($urandom);
      we = 1'($urandom);
      exp = model_read(a);
      dbg_access(we, a, 8'($urandom), rd, lat);
      check("rand_dbg_lat", lat, 2);
      if (!we) check("rand_dbg_rd", rd, exp);
      else model_write(a, dbg_wdata);
    end
    for (int i = 0; i < 20; i++)
      core_access(9'($urandom), 1'b0, 8'h00, "rand_after_dbg");

    core_hold = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h041; dbg_wdata = 8'hEE;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dbg_ack) acks++;
    end
    dbg_req = 1'b0;
    check("nohold_acks", acks, 0);
    core_access(9'h041, 1'b0, 8'h00, "nohold_041");

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    core_hold = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h040;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(n, acks);
    dbg_req = 1'b0; core_hold = 1'b0;
    check("rescrub_cycles", n, 336);
    check("rescrub_acks", acks, 0);
    gpr_m.delete();
    core_access(9'h040, 1'b0, 8'h00, "rescrub_040");
    core_access(9'h071, 1'b0, 8'h00, "rescrub_071");
    core_access(9'h120, 1'b0, 8'h00, "rescrub_120");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
